// File: rtl/bmem_adapter_pkg.sv
// Shared types and constants for the burst-memory adapter.
// Latency: n/a (types only).
// Backpressure: n/a.
package bmem_adapter_pkg;
    localparam int ADDR_BITS = 32;
    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS     = 4;
    localparam int OFFS_BITS = 5;

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [1:0]           beat_idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_BURST = 2'd2
    } issue_state_e;

    // Line-align an address: the byte offset inside a 32-byte line is dropped.
    function automatic addr_t line_align(input addr_t a);
        return {a[ADDR_BITS-1:OFFS_BITS], {OFFS_BITS{1'b0}}};
    endfunction

    // Beat k of a line lives in bits [64k+63:64k].
    function automatic beat_t line_beat(input line_t l, input beat_idx_t k);
        return l[{k, 6'd0} +: BEAT_BITS];
    endfunction
endpackage

// File: rtl/bmem_adapter_if.sv
// Cache-side request/response ports plus burst-memory port of the adapter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on requests, bmem_ready on memory issue.
interface bmem_adapter_if;
    import bmem_adapter_pkg::*;

    logic  i_req_valid;
    addr_t i_req_addr;
    logic  i_req_ready;
    logic  i_resp_valid;
    line_t i_resp_data;

    logic  d_req_valid;
    logic  d_req_write;
    addr_t d_req_addr;
    line_t d_req_wdata;
    logic  d_req_ready;
    logic  d_resp_valid;
    line_t d_resp_data;

    addr_t bmem_addr;
    logic  bmem_read;
    logic  bmem_write;
    beat_t bmem_wdata;
    logic  bmem_ready;
    addr_t bmem_raddr;
    beat_t bmem_rdata;
    logic  bmem_rvalid;

    // Adapter side.
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    // Caches plus memory side.
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_line_assembler.sv
// Per-port read tracker: holds the outstanding line address and assembles 4 returning beats.
// Latency: resp_vld pulses the cycle after the 4th beat; pending clears at the same edge.
// Backpressure: none; beats are accepted whenever beat_vld is high.
module bmem_line_assembler
    import bmem_adapter_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  set_vld,
    input  addr_t set_addr,
    input  logic  beat_vld,
    input  beat_t beat_dat,
    input  addr_t beat_addr,
    output logic  pend,
    output logic  tag_hit,
    output logic  resp_vld,
    output line_t resp_dat
);
    logic      pend_q, pend_d;
    addr_t     addr_q, addr_d;
    beat_idx_t cnt_q, cnt_d;
    line_t     line_q, line_d;
    logic      resp_vld_q, resp_vld_d;

    assign pend     = pend_q;
    assign tag_hit  = pend_q && (line_align(beat_addr) == addr_q);
    assign resp_vld = resp_vld_q;
    assign resp_dat = line_q;

    // Arm on issue; drop each beat into its slot and close out on the last one.
    always_comb begin
        pend_d     = pend_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        resp_vld_d = 1'b0;
        if (set_vld) begin
            pend_d = 1'b1;
            addr_d = line_align(set_addr);
            cnt_d  = '0;
        end
        if (beat_vld) begin
            line_d[{cnt_q, 6'd0} +: BEAT_BITS] = beat_dat;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == beat_idx_t'(BEATS - 1)) begin
                pend_d     = 1'b0;
                resp_vld_d = 1'b1;
            end
        end
    end

    // Tracker state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
            resp_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            resp_vld_q <= resp_vld_d;
        end
    end
endmodule

// File: rtl/bmem_adapter.sv
// Arbitrates i/d cache line requests onto one burst memory; reads return tagged beats out of order.
// Latency: request to bmem_read/bmem_write 1 cycle; last read beat to resp_valid 1 cycle.
// Backpressure: requests accepted only in IDLE; read held and write beat held while bmem_ready is low.
module bmem_adapter
    import bmem_adapter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    bmem_adapter_if.slave bus
);
    issue_state_e state_q, state_d;
    logic         prio_d_q, prio_d_d;     // 1: d wins when both ports are eligible
    logic         rd_is_d_q, rd_is_d_d;   // owner of the read being issued
    line_t        wline_q, wline_d;
    beat_idx_t    beat_q, beat_d;
    addr_t        addr_q, addr_d;
    logic         read_q, read_d;
    logic         write_q, write_d;
    beat_t        wdata_q, wdata_d;

    logic d_pend, i_pend, d_hit, i_hit;
    logic d_elig, i_elig, pick_d, idle, d_take, i_take;
    logic set_d_vld, set_i_vld;
    logic stray_beat;

    assign idle   = (state_q == IDLE);
    assign d_elig = bus.d_req_valid && !d_pend;
    assign i_elig = bus.i_req_valid && !i_pend;
    assign pick_d = d_elig && (!i_elig || prio_d_q);
    // Ready is gated by rst_n so it reads 0 for the whole reset, even with valid high.
    assign d_take = rst_n && idle && pick_d;
    assign i_take = rst_n && idle && i_elig && !pick_d;

    assign bus.d_req_ready = d_take;
    assign bus.i_req_ready = i_take;
    assign bus.bmem_addr   = addr_q;
    assign bus.bmem_read   = read_q;
    assign bus.bmem_write  = write_q;
    assign bus.bmem_wdata  = wdata_q;

    // d claims a shared-address beat first, so a duplicate burst goes to i next.
    assign stray_beat = bus.bmem_rvalid && !d_hit && !i_hit;

    // Issue FSM: latch one request, then hold the read or walk the write beats.
    always_comb begin
        state_d   = state_q;
        prio_d_d  = prio_d_q;
        rd_is_d_d = rd_is_d_q;
        wline_d   = wline_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        read_d    = read_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        set_d_vld = 1'b0;
        set_i_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_take) begin
                    prio_d_d = 1'b0;
                    addr_d   = line_align(bus.d_req_addr);
                    if (bus.d_req_write) begin
                        state_d = WR_BURST;
                        write_d = 1'b1;
                        wline_d = bus.d_req_wdata;
                        beat_d  = '0;
                        wdata_d = line_beat(bus.d_req_wdata, 2'd0);
                    end else begin
                        state_d   = RD_ISSUE;
                        read_d    = 1'b1;
                        rd_is_d_d = 1'b1;
                    end
                end else if (i_take) begin
                    prio_d_d  = 1'b1;
                    addr_d    = line_align(bus.i_req_addr);
                    state_d   = RD_ISSUE;
                    read_d    = 1'b1;
                    rd_is_d_d = 1'b0;
                end
            end
            RD_ISSUE: begin
                if (bus.bmem_ready) begin
                    state_d   = IDLE;
                    read_d    = 1'b0;
                    set_d_vld = rd_is_d_q;
                    set_i_vld = !rd_is_d_q;
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    if (beat_q == beat_idx_t'(BEATS - 1)) begin
                        state_d = IDLE;
                        write_d = 1'b0;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        wdata_d = line_beat(wline_q, beat_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Issue-side registers; all memory-facing outputs come straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_d_q  <= 1'b1;
            rd_is_d_q <= 1'b0;
            wline_q   <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_d_q  <= prio_d_d;
            rd_is_d_q <= rd_is_d_d;
            wline_q   <= wline_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
        end
    end

    // Flags a returning beat that no port is waiting for; the beat is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && bus.bmem_rvalid) begin
            assert (!stray_beat)
                else $warning("bmem_adapter: discarded beat, raddr %h matches no outstanding read", bus.bmem_raddr);
        end
    end

    bmem_line_assembler u_d_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vld  (set_d_vld),
        .set_addr (addr_q),
        .beat_vld (bus.bmem_rvalid && d_hit),
        .beat_dat (bus.bmem_rdata),
        .beat_addr(bus.bmem_raddr),
        .pend     (d_pend),
        .tag_hit  (d_hit),
        .resp_vld (bus.d_resp_valid),
        .resp_dat (bus.d_resp_data)
    );

    bmem_line_assembler u_i_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vld  (set_i_vld),
        .set_addr (addr_q),
        .beat_vld (bus.bmem_rvalid && i_hit && !d_hit),
        .beat_dat (bus.bmem_rdata),
        .beat_addr(bus.bmem_raddr),
        .pend     (i_pend),
        .tag_hit  (i_hit),
        .resp_vld (bus.i_resp_valid),
        .resp_dat (bus.i_resp_data)
    );
endmodule

// File: tb/tb_bmem_adapter.sv
// Directed bench for bmem_adapter: arbitration, read assembly, write bursts, reset abandon.
// Latency: n/a.
// Backpressure: bmem_ready driven low on selected beats.
module tb_bmem_adapter;
    import bmem_adapter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bmem_adapter_if bif();

    bmem_adapter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat k = {seed, 16'hBEA7, k}.
    function automatic line_t mk_line(input logic [31:0] seed);
        line_t l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = {seed, 16'hBEA7, 16'(k)};
        return l;
    endfunction

    // Observers, all sampled on the falling edge.
    int    rd_cyc = 0, d_rsp = 0, i_rsp = 0, stray = 0, overlap = 0;
    int    wr_acc = 0, hold_cyc = 0, gn = 0;
    addr_t rd_addr_seen, wr_addr_seen;
    line_t d_line, i_line;
    beat_t wbeats [16];
    beat_t hold_dat;
    logic  grants [16];

    always @(negedge clk) begin
        if (bif.bmem_read) begin
            rd_cyc++;
            rd_addr_seen = bif.bmem_addr;
        end
        if (bif.bmem_read && bif.bmem_write) overlap++;
        if (bif.bmem_write) begin
            wr_addr_seen = bif.bmem_addr;
            if (bif.bmem_ready) begin
                if (wr_acc < 16) wbeats[wr_acc] = bif.bmem_wdata;
                wr_acc++;
            end else begin
                hold_cyc++;
                hold_dat = bif.bmem_wdata;
            end
        end
        if (bif.d_resp_valid) begin
            d_rsp++;
            d_line = bif.d_resp_data;
        end
        if (bif.i_resp_valid) begin
            i_rsp++;
            i_line = bif.i_resp_data;
        end
        if (bif.d_req_ready && gn < 16) begin
            grants[gn] = 1'b1;
            gn++;
        end
        if (bif.i_req_ready && gn < 16) begin
            grants[gn] = 1'b0;
            gn++;
        end
        if (dut.stray_beat) stray++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 256'({bif.bmem_read, bif.bmem_write, bif.i_req_ready, bif.d_req_ready,
                                 bif.i_resp_valid, bif.d_resp_valid}), 256'(0));
        chk({tag, "_addr"}, 256'(bif.bmem_addr), 256'(0));
        chk({tag, "_wdata"}, 256'(bif.bmem_wdata), 256'(0));
        chk({tag, "_rdata"}, bif.i_resp_data | bif.d_resp_data, 256'(0));
    endtask

    // Present one request and wait (bounded) for its acceptance edge.
    task automatic do_req(input logic is_d, input logic wr, input addr_t a, input line_t wd);
        logic ok;
        ok = 1'b0;
        if (is_d) begin
            bif.d_req_valid = 1'b1;
            bif.d_req_write = wr;
            bif.d_req_addr  = a;
            bif.d_req_wdata = wd;
        end else begin
            bif.i_req_valid = 1'b1;
            bif.i_req_addr  = a;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ok = is_d ? bif.d_req_ready : bif.i_req_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bif.d_req_valid = 1'b0;
        bif.d_req_write = 1'b0;
        bif.i_req_valid = 1'b0;
        if (is_d) chk("d_accept", 256'(ok), 256'(1));
        else      chk("i_accept", 256'(ok), 256'(1));
    endtask

    // Both ports request reads in the same cycle; each drops valid once taken.
    task automatic both_read(input addr_t da, input addr_t ia);
        logic dd, ii;
        dd = 1'b0;
        ii = 1'b0;
        bif.d_req_valid = 1'b1;
        bif.d_req_write = 1'b0;
        bif.d_req_addr  = da;
        bif.i_req_valid = 1'b1;
        bif.i_req_addr  = ia;
        for (int k = 0; k < 20 && !(dd && ii); k++) begin
            @(negedge clk);
            if (bif.d_req_ready) dd = 1'b1;
            if (bif.i_req_ready) ii = 1'b1;
            @(posedge clk);
            #1;
            if (dd) bif.d_req_valid = 1'b0;
            if (ii) bif.i_req_valid = 1'b0;
        end
        bif.d_req_valid = 1'b0;
        bif.i_req_valid = 1'b0;
        chk("both_accept", 256'({dd, ii}), 256'(2'b11));
        cyc(2);
    endtask

    task automatic send_beats(input addr_t a, input line_t l);
        for (int k = 0; k < 4; k++) begin
            bif.bmem_rvalid = 1'b1;
            bif.bmem_raddr  = a;
            bif.bmem_rdata  = l[k*64 +: 64];
            cyc(1);
        end
        bif.bmem_rvalid = 1'b0;
        cyc(2);
    endtask

    line_t la, lb;
    int    r0, i0, d0, g0, w0, h0, s0;

    initial begin
        bif.i_req_valid = 1'b0;
        bif.i_req_addr  = '0;
        bif.d_req_valid = 1'b0;
        bif.d_req_write = 1'b0;
        bif.d_req_addr  = '0;
        bif.d_req_wdata = '0;
        bif.bmem_ready  = 1'b1;
        bif.bmem_raddr  = '0;
        bif.bmem_rdata  = '0;
        bif.bmem_rvalid = 1'b0;
        rst_n = 1'b0;

        // Reset: outputs idle even with both requests asserted.
        bif.d_req_valid = 1'b1;
        bif.i_req_valid = 1'b1;
        #12;
        chk_zero("reset");
        bif.d_req_valid = 1'b0;
        bif.i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);

        // Simultaneous reads, twice: grant order d, i, d, i.
        g0 = gn;
        both_read(32'h0000_6000, 32'h0000_7000);
        send_beats(32'h0000_6000, mk_line(32'h6000));
        send_beats(32'h0000_7000, mk_line(32'h7000));
        both_read(32'h0000_6100, 32'h0000_7100);
        send_beats(32'h0000_6100, mk_line(32'h6100));
        send_beats(32'h0000_7100, mk_line(32'h7100));
        chk("grant_cnt", 256'(gn - g0), 256'(4));
        chk("grant0_d", 256'(grants[g0]),     256'(1));
        chk("grant1_i", 256'(grants[g0 + 1]), 256'(0));
        chk("grant2_d", 256'(grants[g0 + 2]), 256'(1));
        chk("grant3_i", 256'(grants[g0 + 3]), 256'(0));
        chk("grant_d_line", d_line, mk_line(32'h6100));
        chk("grant_i_line", i_line, mk_line(32'h7100));

        // Single i read of 0x1000.
        r0 = rd_cyc;
        i0 = i_rsp;
        la = mk_line(32'h1000);
        do_req(1'b0, 1'b0, 32'h0000_1000, '0);
        chk("rd_latency", 256'(bif.bmem_read), 256'(1));
        cyc(3);
        chk("rd_cycles", 256'(rd_cyc - r0), 256'(1));
        chk("rd_addr", 256'(rd_addr_seen), 256'(32'h0000_1000));
        send_beats(32'h0000_1000, la);
        chk("i_rsp_pulses", 256'(i_rsp - i0), 256'(1));
        chk("i_line", i_line, la);

        // d write of 0x2040 with beat 2 stalled for three cycles.
        w0 = wr_acc;
        h0 = hold_cyc;
        d0 = d_rsp;
        lb = mk_line(32'h2040);
        do_req(1'b1, 1'b1, 32'h0000_2040, lb);
        cyc(2);
        bif.bmem_ready = 1'b0;
        cyc(3);
        bif.bmem_ready = 1'b1;
        cyc(4);
        chk("wr_beats", 256'(wr_acc - w0), 256'(4));
        for (int k = 0; k < 4; k++) chk("wr_beat", 256'(wbeats[w0 + k]), 256'(lb[k*64 +: 64]));
        chk("wr_hold_cyc", 256'(hold_cyc - h0), 256'(3));
        chk("wr_hold_dat", 256'(hold_dat), 256'(lb[191:128]));
        chk("wr_addr", 256'(wr_addr_seen), 256'(32'h0000_2040));
        chk("wr_no_resp", 256'(d_rsp - d0), 256'(0));
        chk("wr_done", 256'(bif.bmem_write), 256'(0));

        // Interleaved returns: d at 0x3000, i at 0x4000.
        d0 = d_rsp;
        i0 = i_rsp;
        la = mk_line(32'h3000);
        lb = mk_line(32'h4000);
        both_read(32'h0000_3000, 32'h0000_4000);
        for (int k = 0; k < 8; k++) begin
            bif.bmem_rvalid = 1'b1;
            bif.bmem_raddr  = k[0] ? 32'h0000_4000 : 32'h0000_3000;
            bif.bmem_rdata  = k[0] ? lb[(k/2)*64 +: 64] : la[(k/2)*64 +: 64];
            cyc(1);
        end
        bif.bmem_rvalid = 1'b0;
        cyc(2);
        chk("ilv_pulses", 256'({16'(d_rsp - d0), 16'(i_rsp - i0)}), 256'({16'd1, 16'd1}));
        chk("ilv_d_line", d_line, la);
        chk("ilv_i_line", i_line, lb);

        // Same address on both ports: first burst to d, second to i.
        d0 = d_rsp;
        i0 = i_rsp;
        la = mk_line(32'h5A00);
        lb = mk_line(32'h5B00);
        both_read(32'h0000_5000, 32'h0000_5000);
        send_beats(32'h0000_5000, la);
        chk("same_first_d", 256'({16'(d_rsp - d0), 16'(i_rsp - i0)}), 256'({16'd1, 16'd0}));
        chk("same_d_line", d_line, la);
        send_beats(32'h0000_5000, lb);
        chk("same_second_i", 256'(i_rsp - i0), 256'(1));
        chk("same_i_line", i_line, lb);

        // Reset while beat 1 of a write is on the bus; a stale beat is dropped afterwards.
        la = mk_line(32'h2080);
        do_req(1'b1, 1'b1, 32'h0000_2080, la);
        cyc(1);
        chk("mid_beat1", 256'(bif.bmem_wdata), 256'(la[127:64]));
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        s0 = stray;
        d0 = d_rsp;
        i0 = i_rsp;
        bif.bmem_rvalid = 1'b1;
        bif.bmem_raddr  = 32'h0000_2080;
        bif.bmem_rdata  = 64'hDEAD_BEEF_0000_0001;
        cyc(1);
        bif.bmem_rvalid = 1'b0;
        cyc(3);
        chk("stray_flagged", 256'(stray - s0), 256'(1));
        chk("stray_no_resp", 256'((d_rsp - d0) + (i_rsp - i0)), 256'(0));
        chk("post_rst_idle", 256'({bif.bmem_read, bif.bmem_write}), 256'(0));

        chk("no_overlap", 256'(overlap), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bmem_adapter.md
BMEM_ADAPTER -- requirements
Module: bmem_adapter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  instruction-cache line read request.
- i_req_addr  in  32  line address.
- i_req_ready  out  1  request accepted this cycle.
- i_resp_valid  out  1  one-cycle pulse, line delivered.
- i_resp_data  out  256  read line.
- d_req_valid  in  1  data-cache request.
- d_req_write  in  1  1 = line writeback, 0 = line read.
- d_req_addr  in  32  line address.
- d_req_wdata  in  256  writeback line.
- d_req_ready  out  1  request accepted this cycle.
- d_resp_valid  out  1  one-cycle pulse, read line delivered; never pulses for writes.
- d_resp_data  out  256  read line.
- bmem_addr  out  32  burst address.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat data.
- bmem_ready  in  1  memory accepts the read request or write beat this cycle.
- bmem_raddr  in  32  address tag of the returning beat.
- bmem_rdata  in  64  returning beat data.
- bmem_rvalid  in  1  returning beat valid.

Function
REQ-003 SHALL drive bmem_addr with bits [4:0] forced to zero; a line is 4 beats of 64 bits, and beat k maps to line bits [64k+63:64k].
REQ-004 SHALL use issue FSM states IDLE, RD_ISSUE and WR_BURST; the request port SHALL accept only in IDLE.
REQ-005 In IDLE, a port is eligible when its valid is high and it has no outstanding read.
- A port's req_ready SHALL be high for exactly the cycle its request is latched.
- Arbitration SHALL be alternating priority when both ports are eligible (d first after reset, then the port not granted last).
- A single eligible port SHALL be granted immediately.
REQ-006 A latched read SHALL move to RD_ISSUE.
- bmem_read=1 with the latched address SHALL be held until a cycle with bmem_ready=1.
- It SHALL then return to IDLE and mark that port outstanding.
- Minimum request-to-bmem_read latency is 1 cycle.
REQ-007 A latched write SHALL move to WR_BURST.
- SHALL drive bmem_write=1 with beats 0..3 in order.
- SHALL advance the beat counter only on bmem_ready=1 and hold the current beat while ready is low.
- SHALL return to IDLE after beat 3 is accepted; a 4-beat burst takes at least 4 cycles.
REQ-008 bmem_read and bmem_write SHALL never be high in the same cycle; both SHALL be 0 in IDLE.
REQ-009 The response path SHALL run independently of the issue FSM, including during WR_BURST.
- On bmem_rvalid, the beat SHALL be stored at the port whose outstanding address equals bmem_raddr, using that port's 2-bit beat counter.
REQ-010 After the 4th beat, the registered resp_valid SHALL pulse in the next cycle with the assembled line, and the port's outstanding flag SHALL clear that same cycle.
- The port SHALL be eligible again in IDLE from the following cycle.
REQ-011 If both ports are outstanding to the same address, the first returning burst SHALL complete the d port and the second the i port.
REQ-012 A beat whose raddr matches no outstanding port SHALL be discarded and SHALL trigger a simulation-only assertion.

Reset
REQ-013 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and outstanding flags, beat counters and the arbitration pointer (d first) SHALL be cleared.
REQ-014 Reset mid-burst or mid-response SHALL abandon the operation; beats arriving after reset release for pre-reset requests SHALL be discarded per REQ-012.

Structure
REQ-015 Shared package SHALL hold LINE_BITS=256, BEAT_BITS=64, BEATS=4, the issue-state enum and the line typedef.
REQ-016 One sub-module, bmem_line_assembler, SHALL be instantiated per port (tag compare, beat counter, line register, resp pulse).

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- i read 0x0000_1000, memory returns 4 beats -> bmem_read one cycle, i_resp_valid one pulse, data matches beats in order.
- d write 0x0000_2040 with bmem_ready low on beat 2 for 3 cycles -> bmem_addr 0x0000_2040, beats 0..3 exact, beat 2 held, no d_resp_valid.
- i and d read requests in the same cycle twice -> grant order d, i, d, i.
- Both outstanding, memory returns d burst (0x3000) interleaved with i burst (0x4000) beats -> each line assembled correctly.
- rst_n low during WR_BURST beat 1 -> outputs 0 immediately; a stale beat afterwards is discarded and the assertion fires.
- Both ports read 0x5000 -> first burst completes d, second completes i.
